// File: rtl/desplazamiento_jump_address.sv
// Jump-address shift stage: registers {jumpAddress, 2'b00} with a one-cycle valid.
// Optional JUMP_TARGET_EN adds pc_upper/jump_target for the full 32-bit jump target.
module desplazamiento_jump_address (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [25:0] jumpAddress,
`ifdef JUMP_TARGET_EN
  input  logic [3:0]  pc_upper,
  output logic [31:0] jump_target,
`endif
  output logic [27:0] output_jump,
  output logic        out_valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      output_jump <= '0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Result holds while in_valid is low; only out_valid drops.
      if (in_valid) begin
        output_jump <= {jumpAddress, 2'b00};
      end
    end
  end

`ifdef JUMP_TARGET_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      jump_target <= '0;
    end else if (in_valid) begin
      jump_target <= {pc_upper, jumpAddress, 2'b00};
    end
  end
`endif

endmodule

// File: tb/tb_desplazamiento_jump_address.sv
// Self-checking bench for desplazamiento_jump_address (directed plus random stimulus).
// Define JUMP_TARGET_EN to also check the 32-bit jump_target path.
module tb_desplazamiento_jump_address;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [25:0] jumpAddress;
  logic [27:0] output_jump;
  logic        out_valid;
`ifdef JUMP_TARGET_EN
  logic [3:0]  pc_upper;
  logic [31:0] jump_target;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference state, computed arithmetically from the captured fields.
  longint unsigned exp_jump   = 0;
  longint unsigned exp_target = 0;
  bit              exp_valid  = 1'b0;

  desplazamiento_jump_address dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .jumpAddress (jumpAddress),
`ifdef JUMP_TARGET_EN
    .pc_upper    (pc_upper),
    .jump_target (jump_target),
`endif
    .output_jump (output_jump),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare just after the edge.
  task automatic step(input bit rst, input bit v, input logic [27:0] raw_addr, input logic [3:0] pcu);
    logic [25:0] a;
    a = raw_addr[25:0];
    reset       = rst;
    in_valid    = v;
    jumpAddress = a;
`ifdef JUMP_TARGET_EN
    pc_upper    = pcu;
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      exp_jump   = 0;
      exp_target = 0;
      exp_valid  = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        exp_jump   = longint'(a) * 4;
        exp_target = longint'(pcu) * 64'h1000_0000 + longint'(a) * 4;
      end
    end
    check("output_jump", {4'h0, output_jump}, exp_jump[31:0]);
    check("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
`ifdef JUMP_TARGET_EN
    check("jump_target", jump_target, exp_target[31:0]);
`endif
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; jumpAddress = '0;
`ifdef JUMP_TARGET_EN
    pc_upper = '0;
`endif
    #2;
    // Reset overrides in_valid with all-ones address.
    step(1'b1, 1'b1, 28'h3FFFFFF, 4'hF);
    step(1'b1, 1'b1, 28'h3FFFFFF, 4'hF);
    check("reset_literal", {4'h0, output_jump}, 32'h0);

    step(1'b0, 1'b1, 28'h0, 4'h0);
    check("zero_literal", {4'h0, output_jump}, 32'h0000000);

    step(1'b0, 1'b1, 28'hFFFFFFF, 4'h4);
    check("ones_literal", {4'h0, output_jump}, 32'hFFFFFFC);
`ifdef JUMP_TARGET_EN
    check("target_literal", jump_target, 32'h4FFFFFFC);
`endif

    step(1'b0, 1'b1, 28'hABCDF11, 4'h1);
    check("trunc_literal", {4'h0, output_jump}, 32'hAF37C44);
    step(1'b0, 1'b0, 28'h1234567, 4'h2);
    check("hold_literal", {4'h0, output_jump}, 32'hAF37C44);

    step(1'b0, 1'b1, 28'h0000001, 4'h3);
    check("b2b_first", {4'h0, output_jump}, 32'h0000004);
    step(1'b0, 1'b1, 28'h2000000, 4'h3);
    check("b2b_second", {4'h0, output_jump}, 32'h8000000);
    check("b2b_valid", {31'h0, out_valid}, 32'h1);

    // Mid-stream reset discards the in-flight value.
    step(1'b1, 1'b1, 28'h155AA55, 4'h7);
    step(1'b0, 1'b0, 28'h0, 4'h0);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           28'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/desplazamiento_jump_address.md
# desplazamiento_jump_address

Jump-address shift stage for the MIPS-style datapath. Takes the 26-bit J-type instruction index and shifts it left by two to form the 28-bit word-aligned jump offset. Optionally concatenates the upper four PC bits to form the full 32-bit jump target. Sits between instruction decode and the PC-select mux, with one registered pipeline stage.

## Interface

One clock; reset is synchronous and active-high.

Parameters: none.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  jumpAddress is valid this cycle
- jumpAddress  input  26  J-type instruction index field (instr[25:0])
- output_jump  output  28  registered {jumpAddress, 2'b00}
- out_valid  output  1  output_jump (and jump_target) valid this cycle
- pc_upper  input  4  PC+4 bits [31:28]; present only with JUMP_TARGET_EN
- jump_target  output  32  registered {pc_upper, jumpAddress, 2'b00}; present only with JUMP_TARGET_EN

## Operation

- Each rising edge with reset=0 and in_valid=1:
  - output_jump <= {jumpAddress, 2'b00}.
  - out_valid <= 1.
  - With JUMP_TARGET_EN: jump_target <= {pc_upper, jumpAddress, 2'b00}.
- Rising edge with reset=0 and in_valid=0:
  - output_jump and jump_target hold their previous values.
  - out_valid <= 0.
- Pure bit placement:
  - No arithmetic, no sign extension, no overflow.
  - output_jump[1:0] is always 2'b00.
  - output_jump[27:2] equals the captured jumpAddress bit-for-bit.
- Inputs are exactly 26 bits. Stimulus wider than 26 bits is truncated by the driver to bits [25:0] before reaching the port; the block sees only those bits.
- No backpressure: a new valid input every cycle is accepted and overwrites the previous result.

## Timing

- Latency: one clock, from in_valid/jumpAddress sampled at edge N to output_jump/out_valid valid after edge N.
- Throughput: one address per clock.
- Reset:
  - On any edge with reset=1: output_jump=28'h0, jump_target=32'h0, out_valid=0.
  - Reset overrides in_valid.
  - Reset asserted mid-stream discards the in-flight value.
  - First valid output after release is one clock after the first in_valid=1 edge.
- Outputs are driven only from flops; there is no combinational path from input to output.

## Configuration

- Macro: JUMP_TARGET_EN.
- Defined:
  - pc_upper input and jump_target output exist.
  - jump_target is registered alongside output_jump and shares out_valid.
- Undefined:
  - Neither port exists.
  - Only the 28-bit output_jump path is built.
- output_jump behaviour is identical in both builds.

## Test plan

- Reset: hold reset=1 for 2 clocks with in_valid=1, jumpAddress=26'h3FFFFFF -> output_jump=28'h0, out_valid=0 throughout.
- Zero input: jumpAddress=26'h0, in_valid=1 -> next clock output_jump=28'h0000000, out_valid=1.
- All ones: jumpAddress=26'h3FFFFFF (driven as 26'hFFFFFFF, truncated) -> output_jump=28'hFFFFFFC.
- Truncated pattern: jumpAddress driven as 26'hABCDF11, i.e. 26'h2BCDF11 -> output_jump=28'hAF37C44. The following cycle, in_valid=0 -> value holds and out_valid=0.
- Back-to-back: 26'h0000001 then 26'h2000000 on consecutive clocks -> output_jump=28'h0000004 then 28'h8000000, with out_valid=1 on both cycles.
- JUMP_TARGET_EN build: pc_upper=4'h4, jumpAddress=26'h3FFFFFF -> jump_target=32'h4FFFFFFC and output_jump=28'hFFFFFFC.
